// File: rtl/press_detector_multi.sv
// press_detector_multi: N-channel push-button front end.
// Each channel debounces its active level (signal XOR nc), classifies a press
// as short or long, emits registered one-cycle pulses and keeps sticky flags.
module press_detector_multi #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int CNT_W           = $clog2(LONG_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] signal,
  input  logic [NUM_CH-1:0] nc,
  input  logic [NUM_CH-1:0] flag_clr,
  output logic [NUM_CH-1:0] held,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] long_pulse,
  output logic [NUM_CH-1:0] press_flag,
  output logic [NUM_CH-1:0] long_flag
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DBD  = 3'd1;  // debouncing the press edge
  localparam logic [2:0] S_DOWN = 3'd2;  // pressed, still short
  localparam logic [2:0] S_LONG = 3'd3;  // pressed, long already reported
  localparam logic [2:0] S_DBU  = 3'd4;  // debouncing the release edge

  // deb_cnt counts samples already accepted, so the edge that consumes the
  // DEBOUNCE_CYCLES-th consecutive sample sees deb_cnt == DEB_LAST.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYCLES - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [2:0]       st, st_n;
    logic [CNT_W-1:0] deb_cnt, deb_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    logic             was_long, long_n;   // long_pulse already fired for this press
    logic             pp, pp_n, lp, lp_n;
    logic             pf, lf;
    logic             act, in_hold;

    assign act     = signal[i] ^ nc[i];
    assign in_hold = (st == S_DOWN) || (st == S_LONG) || (st == S_DBU);

    // Next-state: debounce transitions first, then held-phase bookkeeping.
    always_comb begin
      st_n   = st;
      deb_n  = deb_cnt;
      hold_n = hold_cnt;
      long_n = was_long;
      pp_n   = 1'b0;
      lp_n   = 1'b0;
      case (st)
        S_IDLE: if (act) begin
          if (DEBOUNCE_CYCLES == 1) begin st_n = S_DOWN; hold_n = 1; end
          else begin st_n = S_DBD; deb_n = 1; end
        end
        S_DBD: begin
          if (!act) begin st_n = S_IDLE; deb_n = '0; end
          else if (deb_cnt == DEB_LAST) begin st_n = S_DOWN; deb_n = '0; hold_n = 1; end
          else deb_n = deb_cnt + 1'b1;
        end
        S_DOWN, S_LONG: if (!act) begin
          if (DEBOUNCE_CYCLES == 1) st_n = S_IDLE;
          else begin st_n = S_DBU; deb_n = 1; end
        end
        S_DBU: begin
          if (act) begin st_n = was_long ? S_LONG : S_DOWN; deb_n = '0; end
          else if (deb_cnt == DEB_LAST) begin st_n = S_IDLE; deb_n = '0; end
          else deb_n = deb_cnt + 1'b1;
        end
        default: begin st_n = S_IDLE; deb_n = '0; hold_n = '0; long_n = 1'b0; end
      endcase
      if (in_hold && st_n == S_IDLE) begin
        // release accepted: report a short press unless it already went long
        pp_n   = ~was_long;
        hold_n = '0;
        long_n = 1'b0;
      end else if (in_hold) begin
        if (hold_cnt != LONG_MAX) hold_n = hold_cnt + 1'b1;
        if (!was_long && hold_cnt == LONG_M1) begin
          lp_n   = 1'b1;
          long_n = 1'b1;
          if (st_n == S_DOWN) st_n = S_LONG;
        end
      end
    end

    // State, counters, pulses and sticky flags (set beats clear).
    always_ff @(posedge clk) begin
      if (reset) begin
        st       <= S_IDLE;
        deb_cnt  <= '0;
        hold_cnt <= '0;
        was_long <= 1'b0;
        pp       <= 1'b0;
        lp       <= 1'b0;
        pf       <= 1'b0;
        lf       <= 1'b0;
      end else begin
        st       <= st_n;
        deb_cnt  <= deb_n;
        hold_cnt <= hold_n;
        was_long <= long_n;
        pp       <= pp_n;
        lp       <= lp_n;
        pf       <= pp | (pf & ~flag_clr[i]);
        lf       <= lp | (lf & ~flag_clr[i]);
      end
    end

    assign held[i]        = in_hold;
    assign press_pulse[i] = pp;
    assign long_pulse[i]  = lp;
    assign press_flag[i]  = pf;
    assign long_flag[i]   = lf;
  end

endmodule

// File: tb/tb_press_detector_multi.sv
// Directed bench for press_detector_multi with NUM_CH=4, DEBOUNCE=4, LONG=20.
// Cycle c is the clock period following the c-th edge of a scenario; outputs
// are sampled 1 ns after the edge and inputs for cycle c are applied then.
module tb_press_detector_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] signal, nc, flag_clr;
  logic [3:0] held, press_pulse, long_pulse, press_flag, long_flag;
  logic [3:0] act_v;
  int         n_chk = 0;
  int         n_fail = 0;

  press_detector_multi #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20)) dut (
    .clk(clk), .reset(reset), .signal(signal), .nc(nc), .flag_clr(flag_clr),
    .held(held), .press_pulse(press_pulse), .long_pulse(long_pulse),
    .press_flag(press_flag), .long_flag(long_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive();
    signal = act_v ^ nc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      signal = 4'($urandom);
      tick();
      n_chk++;
      if ({held, press_pulse, long_pulse, press_flag, long_flag} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d got=%h want=0", k,
                 {held, press_pulse, long_pulse, press_flag, long_flag});
      end
    end
    reset = 1'b0;
    act_v = 4'h0; drive();
    tick();
    n_chk++;
    if ({held, press_pulse, long_pulse, press_flag, long_flag} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=0",
               {held, press_pulse, long_pulse, press_flag, long_flag});
    end
    repeat (6) tick();
  endtask

  // ch0, normally-open: act high cycles 0..9
  task automatic test_short_press();
    for (int c = 0; c <= 20; c++) begin
      n_chk++;
      if (held[0] !== (c >= 4 && c <= 13)) begin
        n_fail++; $display("FAIL short_held c=%0d got=%b want=%b", c, held[0], (c >= 4 && c <= 13));
      end
      n_chk++;
      if (press_pulse[0] !== (c == 14)) begin
        n_fail++; $display("FAIL short_pulse c=%0d got=%b want=%b", c, press_pulse[0], (c == 14));
      end
      n_chk++;
      if (press_flag[0] !== (c >= 15)) begin
        n_fail++; $display("FAIL short_flag c=%0d got=%b want=%b", c, press_flag[0], (c >= 15));
      end
      n_chk++;
      if (long_pulse[0] !== 1'b0 || long_flag[0] !== 1'b0) begin
        n_fail++; $display("FAIL short_nolong c=%0d got=%b%b want=00", c, long_pulse[0], long_flag[0]);
      end
      act_v[0] = (c < 9) ? 1'b1 : ((c == 9) ? 1'b1 : 1'b0);
      drive();
      tick();
    end
  endtask

  // ch1, normally-closed: signal low (active) cycles 0..29
  task automatic test_long_press();
    for (int c = 0; c <= 40; c++) begin
      n_chk++;
      if (held[1] !== (c >= 4 && c <= 33)) begin
        n_fail++; $display("FAIL long_held c=%0d got=%b want=%b", c, held[1], (c >= 4 && c <= 33));
      end
      n_chk++;
      if (long_pulse[1] !== (c == 23)) begin
        n_fail++; $display("FAIL long_pulse c=%0d got=%b want=%b", c, long_pulse[1], (c == 23));
      end
      n_chk++;
      if (long_flag[1] !== (c >= 24)) begin
        n_fail++; $display("FAIL long_flag c=%0d got=%b want=%b", c, long_flag[1], (c >= 24));
      end
      n_chk++;
      if (press_pulse[1] !== 1'b0 || press_flag[1] !== 1'b0) begin
        n_fail++; $display("FAIL long_nopress c=%0d got=%b%b want=00", c, press_pulse[1], press_flag[1]);
      end
      act_v[1] = (c < 30);
      drive();
      tick();
    end
    flag_clr = 4'b0010;
    tick();
    flag_clr = 4'b0000;
    n_chk++;
    if (long_flag[1] !== 1'b0) begin
      n_fail++; $display("FAIL long_flag_clr got=%b want=0", long_flag[1]);
    end
  endtask

  // ch2: rejected bursts, then a press with a 2-cycle dip that still goes long
  task automatic test_glitch();
    for (int c = 0; c <= 19; c++) begin
      n_chk++;
      if (held[2] !== 1'b0 || press_pulse[2] !== 1'b0 || long_pulse[2] !== 1'b0) begin
        n_fail++; $display("FAIL glitch_burst c=%0d got=%b%b%b want=000", c, held[2], press_pulse[2], long_pulse[2]);
      end
      act_v[2] = ((c % 4) != 3);
      drive();
      tick();
    end
    act_v[2] = 1'b0; drive();
    repeat (4) tick();
    for (int c = 0; c <= 40; c++) begin
      n_chk++;
      if (held[2] !== (c >= 4 && c <= 33)) begin
        n_fail++; $display("FAIL glitch_held c=%0d got=%b want=%b", c, held[2], (c >= 4 && c <= 33));
      end
      n_chk++;
      if (long_pulse[2] !== (c == 23)) begin
        n_fail++; $display("FAIL glitch_long c=%0d got=%b want=%b", c, long_pulse[2], (c == 23));
      end
      n_chk++;
      if (press_pulse[2] !== 1'b0) begin
        n_fail++; $display("FAIL glitch_press c=%0d got=%b want=0", c, press_pulse[2]);
      end
      act_v[2] = (c < 8) || (c >= 10 && c < 30);
      drive();
      tick();
    end
  endtask

  // ch0 pulse meets flag_clr; ch1 short and ch2 long run concurrently
  task automatic test_back_to_back();
    flag_clr = 4'hF; tick(); flag_clr = 4'h0;
    for (int c = 0; c <= 34; c++) begin
      n_chk++;
      if (press_pulse[0] !== (c == 14) || press_flag[0] !== (c >= 15)) begin
        n_fail++; $display("FAIL sim_ch0 c=%0d got=%b%b want=%b%b", c, press_pulse[0], press_flag[0], (c == 14), (c >= 15));
      end
      n_chk++;
      if (held[1] !== (c >= 4 && c <= 13) || press_pulse[1] !== (c == 14) || long_pulse[1] !== 1'b0) begin
        n_fail++; $display("FAIL sim_ch1 c=%0d got=%b%b%b want=%b%b0", c, held[1], press_pulse[1], long_pulse[1], (c >= 4 && c <= 13), (c == 14));
      end
      n_chk++;
      if (held[2] !== (c >= 6 && c <= 30) || long_pulse[2] !== (c == 25) || press_pulse[2] !== 1'b0) begin
        n_fail++; $display("FAIL sim_ch2 c=%0d got=%b%b%b want=%b%b0", c, held[2], long_pulse[2], press_pulse[2], (c >= 6 && c <= 30), (c == 25));
      end
      act_v[0] = (c < 10);
      act_v[1] = (c < 10);
      act_v[2] = (c >= 2 && c < 27);
      flag_clr[0] = (c <= 14);
      drive();
      tick();
    end
    flag_clr = 4'h0;
  endtask

  // ch3: reset lands while hold_cnt is 10
  task automatic test_reset_mid_press();
    for (int c = 0; c <= 13; c++) begin
      act_v[3] = 1'b1; drive();
      if (c == 13) begin
        n_chk++;
        if (held[3] !== 1'b1) begin
          n_fail++; $display("FAIL midrst_pre got=%b want=1", held[3]);
        end
        reset = 1'b1;
        act_v[3] = 1'b0; drive();
      end
      tick();
    end
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_chk++;
      if ({held, press_pulse, long_pulse, press_flag, long_flag} !== 20'h0) begin
        n_fail++; $display("FAIL midrst_out c=%0d got=%h want=0", c,
                           {held, press_pulse, long_pulse, press_flag, long_flag});
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; flag_clr = 4'h0; nc = 4'b0010; act_v = 4'h0; drive();
    test_reset();
    test_short_press();
    test_long_press();
    test_glitch();
    test_back_to_back();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
